// File: rtl/i2s_sample_rx.sv
// I2S receiver: oversamples sck/ws/sd in the clock domain and delivers one channel as signed SAMPLE_W-bit words.
// Define I2S_SAMPLE_RX_ERRCNT_EN to add the saturating 8-bit err_cnt output.
module i2s_sample_rx #(
  parameter int SAMPLE_W = 18,
  parameter int CNT_W    = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sck,
  input  logic                ws,
  input  logic                sd,
  input  logic                chsel,
  input  logic                clr_err,
  output logic [SAMPLE_W-1:0] dataout,
  output logic                endata,
`ifdef I2S_SAMPLE_RX_ERRCNT_EN
  output logic [7:0]          err_cnt,
`endif
  output logic                frame_err
);

  // state | meaning
  // IDLE  | waiting for a ws edge into the selected channel
  // SHIFT | collecting MSB-first bits of the selected slot
  // DONE  | word complete, dataout/endata presented for one clock
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [2:0]          sck_sync;
  logic [1:0]          ws_sync;
  logic [1:0]          sd_sync;
  logic                ws_prev;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [SAMPLE_W-1:0] shift, shift_nxt;
  logic                sck_rise;
  logic                ws_s;
  logic                sd_s;
  logic                ws_edge;
  logic                load;
  logic                err_evt;

  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign ws_s     = ws_sync[1];
  assign sd_s     = sd_sync[1];
  assign ws_edge  = sck_rise & (ws_s != ws_prev);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
      ws_prev  <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[1:0], sck};
      ws_sync  <= {ws_sync[0], ws};
      sd_sync  <= {sd_sync[0], sd};
      if (sck_rise) begin
        ws_prev <= ws_s;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      shift <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shift <= shift_nxt;
    end
  end

  // The sd bit seen on a ws edge is the previous slot's LSB, so it is never shifted.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_nxt = shift;
    load      = 1'b0;
    err_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (ws_edge && (ws_s == chsel)) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
          shift_nxt = '0;
        end
      end
      SHIFT: begin
        if (ws_edge) begin
          err_evt   = 1'b1;
          cnt_nxt   = '0;
          shift_nxt = '0;
          state_nxt = (ws_s == chsel) ? SHIFT : IDLE;
        end else if (sck_rise) begin
          shift_nxt = {shift[SAMPLE_W-2:0], sd_s};
          cnt_nxt   = cnt + CNT_W'(1);
          if (cnt == CNT_W'(SAMPLE_W - 1)) begin
            state_nxt = DONE;
            load      = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output registers load on the entry into DONE so endata is high exactly during DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dataout   <= '0;
      endata    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      endata <= load;
      if (load) begin
        dataout <= shift_nxt;
      end
      if (err_evt) begin
        frame_err <= 1'b1;
      end else if (clr_err) begin
        frame_err <= 1'b0;
      end
    end
  end

`ifdef I2S_SAMPLE_RX_ERRCNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_cnt <= 8'd0;
    end else if (err_evt) begin
      if (clr_err) begin
        err_cnt <= 8'd1;
      end else if (err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end else if (clr_err) begin
      err_cnt <= 8'd0;
    end
  end
`endif

endmodule
